// File: rtl/uart_rx_seq_if.sv
// ---------------------------------------------------------------------------
// uart_rx_seq_if
// Byte-delivery bundle between the UART receive sequencer and its consumer
// (RX FIFO or host logic).
//
//   rx_data    received byte, stable while rx_valid is high
//   rx_valid   byte available, held until accepted
//   rx_ready   consumer accepts rx_data when rx_valid && rx_ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: a new byte was dropped because the previous
//              byte was still unaccepted
//   busy       receiver is somewhere inside a frame (not idle)
//
// Modports:
//   master  - the receiver (drives data/flags, observes ready)
//   slave   - the consumer (observes data/flags, drives ready)
// ---------------------------------------------------------------------------
interface uart_rx_seq_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_seq.sv
// ---------------------------------------------------------------------------
// uart_rx_seq
// UART receive sequencer. Walks the oversample counter and bit counter
// through start / data / stop framing (8N1 by default, LSB first), assembles
// the data bits into a byte and hands it to the consumer on a valid/ready
// handshake. A low stop bit raises a frame-error pulse and parks the
// receiver until the line returns high; a byte arriving while the previous
// one is still unaccepted is dropped with an overrun pulse.
//
// Ports:
//   clk      system clock, all logic on the rising edge
//   rst      synchronous active-high reset
//   tick_en  oversample tick, one-cycle pulse, OVS ticks per bit time
//   rxd      serial input, already synchronised, idle high
//   rx       uart_rx_seq_if.master: rx_data, rx_valid, rx_ready,
//            frame_err, overrun, busy
//
// Parameters:
//   OVS        oversample ticks per bit
//   SAMPLE_PT  START-state count at which the start bit is re-checked
//   DATA_BITS  data bits per frame
//   CNT_LEN    oversample counter width, 2**CNT_LEN >= OVS
// ---------------------------------------------------------------------------
module uart_rx_seq #(
    parameter int OVS       = 16,
    parameter int SAMPLE_PT = 7,
    parameter int DATA_BITS = 8,
    parameter int CNT_LEN   = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick_en,
    input  logic           rxd,
    uart_rx_seq_if.master  rx
);

    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_LEN-1:0] SAMPLE_CNT = CNT_LEN'(SAMPLE_PT);
    localparam logic [CNT_LEN-1:0] OVS_LAST   = CNT_LEN'(OVS - 1);
    localparam logic [BIT_W-1:0]   LAST_BIT   = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    // -----------------------------------------------------------------------
    // Framing state
    // -----------------------------------------------------------------------
    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_LEN-1:0]     os_cnt_reg;
    logic [CNT_LEN-1:0]     os_cnt_next;
    logic [BIT_W-1:0]       bit_cnt_reg;
    logic [BIT_W-1:0]       bit_cnt_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_next;

    // Single-cycle events from the framing FSM into the delivery logic
    logic                   deliver;
    logic                   stop_bad;

    // -----------------------------------------------------------------------
    // Delivery / handshake registers
    // -----------------------------------------------------------------------
    logic [DATA_BITS-1:0]   data_reg;
    logic [DATA_BITS-1:0]   data_next;
    logic                   valid_reg;
    logic                   valid_next;
    logic                   frame_err_reg;
    logic                   frame_err_next;
    logic                   overrun_reg;
    logic                   overrun_next;

    // -----------------------------------------------------------------------
    // Shift-in value: new sample enters at the MSB, everything moves toward
    // bit 0, so after DATA_BITS samples the first (LSB) bit sits in bit 0.
    // -----------------------------------------------------------------------
    logic [DATA_BITS-1:0]   shift_in;

    generate
        for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_msb
                assign shift_in[gi] = rxd;
            end else begin : g_lower
                assign shift_in[gi] = shift_reg[gi + 1];
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Framing FSM: next-state and counter logic. Nothing moves without a tick.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        os_cnt_next  = os_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        deliver      = 1'b0;
        stop_bad     = 1'b0;

        if (tick_en) begin
            case (state_reg)
                IDLE: begin
                    if (!rxd) begin
                        state_next  = START;
                        os_cnt_next = '0;
                    end
                end

                START: begin
                    if (os_cnt_reg != SAMPLE_CNT) begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end else if (rxd) begin
                        // Line went back high by mid-bit: treat as a glitch.
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        os_cnt_next  = '0;
                        bit_cnt_next = '0;
                    end
                end

                DATA: begin
                    if (os_cnt_reg != OVS_LAST) begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end else begin
                        // os_cnt was cleared at the start-bit centre, so
                        // OVS_LAST lands on the centre of each data bit.
                        shift_next   = shift_in;
                        os_cnt_next  = '0;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next = STOP;
                        end
                    end
                end

                STOP: begin
                    if (os_cnt_reg != OVS_LAST) begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end else begin
                        os_cnt_next = '0;
                        if (rxd) begin
                            deliver    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            stop_bad   = 1'b1;
                            state_next = BREAK;
                        end
                    end
                end

                BREAK: begin
                    // A held-low line (break condition) must not look like a
                    // fresh start bit; wait for the line to return high.
                    if (rxd) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Delivery and handshake. A delivery in the same cycle as an accept
    // replaces the byte and keeps valid high; a delivery while the held byte
    // is still unaccepted is dropped and reported as an overrun.
    // -----------------------------------------------------------------------
    always_comb begin
        data_next      = data_reg;
        valid_next     = valid_reg;
        frame_err_next = stop_bad;
        overrun_next   = 1'b0;

        if (deliver) begin
            if (!valid_reg || rx.rx_ready) begin
                data_next  = shift_reg;
                valid_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end else if (valid_reg && rx.rx_ready) begin
            valid_next = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            os_cnt_reg    <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            os_cnt_reg    <= os_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rx.rx_data   = data_reg;
    assign rx.rx_valid  = valid_reg;
    assign rx.frame_err = frame_err_reg;
    assign rx.overrun   = overrun_reg;
    assign rx.busy      = (state_reg != IDLE);

endmodule
